// File: rtl/uart_rx.sv
// UART receiver: oversamples RX_IN at prescale x bit rate, majority-votes three
// mid-bit samples, deserialises LSB-first, checks optional parity and the stop bit.
module uart_rx #(
    parameter int width    = 8,
    parameter int prescale = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_IN,
    input  logic             Par_en,
    input  logic             Par_type,
    output logic [width-1:0] P_data,
    output logic             Data_valid,
    output logic             Par_err,
    output logic             Stp_err
);

    localparam int EW = $clog2(prescale);
    localparam int BW = (width > 1) ? $clog2(width) : 1;
    localparam logic [EW-1:0] EDGE_LAST = EW'(prescale - 1);
    localparam logic [EW-1:0] SMP0      = EW'(prescale / 2 - 1);
    localparam logic [EW-1:0] SMP1      = EW'(prescale / 2);
    localparam logic [EW-1:0] SMP2      = EW'(prescale / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state_q, state_d;
    logic [EW-1:0]    edge_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [2:0]       samp;
    logic [width-1:0] shift_reg;
    logic             par_en_q, par_type_q, par_flag;
    logic             bit_end, maj, par_exp;
    logic             dv_d, perr_d, serr_d;

    assign bit_end = (edge_cnt == EDGE_LAST);
    assign maj     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign par_exp = (^shift_reg) ^ par_type_q;

    always_comb begin
        state_d = state_q;
        dv_d    = 1'b0;
        perr_d  = 1'b0;
        serr_d  = 1'b0;
        case (state_q)
            IDLE:   if (!RX_IN) state_d = START;
            START:  if (bit_end) state_d = maj ? IDLE : DATA;
            DATA:   if (bit_end && bit_cnt == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (bit_end) begin
                        state_d = STOP;
                        perr_d  = (maj != par_exp);
                    end
            STOP:   if (bit_end) begin
                        state_d = IDLE;
                        serr_d  = !maj;
                        dv_d    = maj && !par_flag;
                    end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            samp       <= '0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_type_q <= 1'b0;
            par_flag   <= 1'b0;
            P_data     <= '0;
            Data_valid <= 1'b0;
            Par_err    <= 1'b0;
            Stp_err    <= 1'b0;
        end else begin
            Data_valid <= dv_d;
            Par_err    <= perr_d;
            Stp_err    <= serr_d;
            if (dv_d) P_data <= shift_reg;
            if (state_q == IDLE) begin
                // the detection cycle itself is edge 0 of the start bit
                edge_cnt <= RX_IN ? '0 : EW'(1);
                bit_cnt  <= '0;
                if (!RX_IN) begin
                    par_en_q   <= Par_en;
                    par_type_q <= Par_type;
                    par_flag   <= 1'b0;
                end
            end else begin
                edge_cnt <= bit_end ? '0 : edge_cnt + EW'(1);
                if (edge_cnt == SMP0) samp[0] <= RX_IN;
                if (edge_cnt == SMP1) samp[1] <= RX_IN;
                if (edge_cnt == SMP2) samp[2] <= RX_IN;
                if (state_q == DATA && bit_end) begin
                    shift_reg <= (shift_reg >> 1) | (width'(maj) << (width - 1));
                    bit_cnt   <= bit_cnt + BW'(1);
                end
                if (perr_d) par_flag <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames built from data/parity/stop rules,
// expected strobes and P_data derived per frame by a frame-level model.
module tb_uart_rx;
    localparam int W = 8;
    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         RX_IN = 1'b1;
    logic         Par_en = 1'b0;
    logic         Par_type = 1'b0;
    logic [W-1:0] P_data;
    logic         Data_valid, Par_err, Stp_err;

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] model_pdata = '0;
    bit           pend = 0;
    bit           pend_dv, pend_serr;

    uart_rx #(.width(W), .prescale(P)) dut (
        .clk(clk), .rst(rst), .RX_IN(RX_IN), .Par_en(Par_en), .Par_type(Par_type),
        .P_data(P_data), .Data_valid(Data_valid), .Par_err(Par_err), .Stp_err(Stp_err)
    );

    always #5 clk = ~clk;

    // Checks the end-of-frame cycle T+N*P of the previous frame, if any.
    task automatic check_pend();
        if (pend) begin
            checks++;
            if (Data_valid !== pend_dv || Stp_err !== pend_serr || Par_err !== 1'b0 ||
                P_data !== model_pdata) begin
                errors++;
                $display("FAIL frame_end: got dv=%b serr=%b perr=%b P_data=%h, want dv=%b serr=%b perr=0 P_data=%h",
                         Data_valid, Stp_err, Par_err, P_data, pend_dv, pend_serr, model_pdata);
            end
            pend = 0;
        end
    endtask

    task automatic idle(input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) check_pend();
            else if (Data_valid || Par_err || Stp_err) bad++;
            RX_IN = 1'b1;
        end
        if (n > 1) begin
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL idle_quiet: %0d strobe cycles, want 0", bad);
            end
        end
    endtask

    // glitch: cycle offset within the frame to invert, -1 for none
    task automatic send_frame(input logic [W-1:0] d, input bit pe, input bit pt,
                              input bit bad_par, input bit stop_v, input int glitch);
        int n = W + (pe ? 3 : 2);
        logic [W+2:0] fr;
        bit perr, serr;
        int bad = 0;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < W; i++) fr[i+1] = d[i];
        if (pe) fr[W+1] = (^d) ^ pt ^ bad_par;
        fr[n-1] = stop_v;
        perr = pe && bad_par;
        serr = !stop_v;
        for (int c = 0; c < n * P; c++) begin
            @(negedge clk);
            if (c == 0) check_pend();
            else begin
                if (Data_valid || Stp_err) bad++;
                if (Par_err !== (perr && c == (W + 2) * P)) bad++;
            end
            RX_IN = fr[c / P] ^ (c == glitch);
            // config only matters in the start-detect cycle
            if (c == 0) begin Par_en = pe; Par_type = pt; end
            else begin Par_en = 1'($urandom); Par_type = 1'($urandom); end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL frame_body d=%h: %0d wrong strobe cycles, want 0", d, bad);
        end
        pend      = 1;
        pend_dv   = !perr && !serr;
        pend_serr = serr;
        if (pend_dv) model_pdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (P_data !== '0 || Data_valid !== 0 || Par_err !== 0 || Stp_err !== 0) begin
            errors++;
            $display("FAIL reset_state: P_data=%h dv=%b perr=%b serr=%b, want all 0",
                     P_data, Data_valid, Par_err, Stp_err);
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_parity_even();
        send_frame(8'hA5, 1, 0, 0, 1, -1);
        idle(4);
    endtask

    task automatic test_no_parity_and_par_err();
        send_frame(8'h3C, 0, 0, 0, 1, -1);
        idle(3);
        send_frame(8'h01, 1, 0, 1, 1, -1);
        idle(3);
        send_frame(8'hFF, 1, 1, 0, 1, -1);
        idle(3);
    endtask

    task automatic test_back_to_back();
        send_frame(8'h77, 1, 0, 0, 0, -1);
        send_frame(8'h5A, 1, 0, 0, 1, -1);
        send_frame(8'h81, 0, 0, 1, 0, -1);
        send_frame(8'h24, 1, 1, 1, 0, -1);
        send_frame(8'hE7, 0, 0, 0, 1, -1);
        idle(3);
    endtask

    task automatic test_false_start();
        int bad = 0;
        for (int c = 0; c < P + 6; c++) begin
            @(negedge clk);
            if (Data_valid || Par_err || Stp_err) bad++;
            RX_IN = (c < 2) ? 1'b0 : 1'b1;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL false_start: %0d strobe cycles, want 0", bad);
        end
        send_frame(8'h42, 0, 0, 0, 1, -1);
        idle(2);
    endtask

    task automatic test_glitch();
        send_frame(8'h96, 1, 0, 0, 1, 4 * P + P / 2);
        send_frame(8'h96, 0, 0, 0, 1, 4 * P + P / 2 - 1);
        send_frame(8'h69, 1, 1, 0, 1, 4 * P + P / 2 + 1);
        send_frame(8'h0F, 1, 0, 0, 1, 10 * P + P / 2);
        idle(2);
    endtask

    task automatic test_reset_mid();
        idle(2);
        for (int c = 0; c < 5 * P + 3; c++) begin
            @(negedge clk);
            RX_IN = (c < P) ? 1'b0 : c[0];
        end
        #2 rst = 1'b1;
        #1;
        model_pdata = '0;
        checks++;
        if (P_data !== '0 || Data_valid !== 0 || Par_err !== 0 || Stp_err !== 0) begin
            errors++;
            $display("FAIL reset_mid: P_data=%h dv=%b perr=%b serr=%b, want all 0",
                     P_data, Data_valid, Par_err, Stp_err);
        end
        @(negedge clk);
        rst = 1'b0;
        RX_IN = 1'b1;
        idle(3);
        send_frame(8'hC3, 1, 0, 0, 1, -1);
        idle(2);
    endtask

    task automatic test_random();
        for (int f = 0; f < 30; f++) begin
            logic [W-1:0] d = W'($urandom);
            bit pe = 1'($urandom);
            bit bp = ($urandom_range(0, 4) == 0);
            bit sv = ($urandom_range(0, 4) != 0);
            int n = W + (pe ? 3 : 2);
            int g = -1;
            if ($urandom_range(0, 1) == 1)
                g = $urandom_range(0, n - 1) * P + P / 2 - 1 + $urandom_range(0, 2);
            send_frame(d, pe, 1'($urandom), bp, sv, g);
            idle($urandom_range(0, 3));
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_parity_even();
        test_no_parity_and_par_err();
        test_back_to_back();
        test_false_start();
        test_glitch();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
